sd_init_sequencer: RTL and testbench
====================================

// Module: sd_init_sequencer
// PURPOSE
//  Sequences the byte-wide SPI master through SD-card SPI-mode initialisation:
//  power-up clocks, CMD0, CMD8, CMD55/ACMD41 poll loop, CMD58.
//  Sits between the top-level boot FSM and the SPI master. Owns chip-select and the SPI clock divider.
//  Reports ready/error, card capacity class and the OCR.
// PARAMETERS
//  POWERUP_BYTES  10    0xFF bytes sent with CS high before CMD0 (10 bytes = 80 SCK)
//  NCR_MAX        8     max 0xFF bytes polled for an R1 before timeout
//  ACMD41_RETRY   1000  max CMD55+ACMD41 iterations before error
//  SLOW_DIV       2'b11 clock_divider_o during init (<=400 kHz)
//  FAST_DIV       2'b00 clock_divider_o after success
// PORTS
//  seq_clk_i        in   1   system clock
//  seq_rst_i        in   1   asynchronous, active-high reset
//  start_i          in   1   1-cycle pulse: begin initialisation
//  spi_rx_i         in   8   byte received by the SPI master
//  spi_done_i       in   1   1-cycle pulse: byte exchange complete
//  spi_tx_o         out  8   byte to transmit
//  spi_start_o      out  1   1-cycle pulse: start byte exchange
//  spi_cs_n_o       out  1   card chip-select, active low
//  clock_divider_o  out  2   SPI master SCK divider select
//  busy_o           out  1   sequence in progress
//  ready_o          out  1   init succeeded (sticky until start_i or reset)
//  error_o          out  1   init failed (sticky until start_i or reset)
//  error_code_o     out  3   failure cause, valid while error_o=1
//  card_hc_o        out  1   OCR[30] (CCS): 1 = SDHC/SDXC block addressing
//  ocr_o            out  32  OCR returned by CMD58
// BEHAVIOUR
//  Reset values:
//   - all outputs 0, except spi_cs_n_o=1, spi_tx_o=8'hFF, clock_divider_o=SLOW_DIV
//  Reset mid-operation aborts immediately to IDLE. start_i while busy_o=1 is ignored.
//  Byte handshake:
//   - spi_start_o pulses 1 cycle with spi_tx_o stable; spi_tx_o held until spi_done_i
//   - next spi_start_o is asserted the cycle after spi_done_i; at most one byte in flight
//   - spi_rx_i is sampled on the spi_done_i cycle
//  FSM states: IDLE, POWERUP, SEND_CMD, WAIT_R1, READ_EXT, GAP, EVAL, DONE, ERROR.
//   IDLE: on start_i, clear ready/error/ocr, set busy_o=1, divider=SLOW_DIV -> POWERUP
//   POWERUP: CS high, POWERUP_BYTES x 0xFF -> SEND_CMD(CMD0)
//   SEND_CMD: CS low, shift 6 bytes MSB-first from the 48-bit frame -> WAIT_R1
//   WAIT_R1: tx 0xFF; rx[7]=0 latches R1 -> READ_EXT (CMD8/CMD58) or GAP (others)
//     - NCR_MAX bytes with rx[7]=1 -> ERROR code 1
//   READ_EXT: 4 more 0xFF bytes; rx shifted into a 32-bit reg, MSB-first -> GAP
//   GAP: CS high, one 0xFF byte (8 SCK) -> EVAL
//   EVAL: decides the next command, DONE or ERROR; no SPI traffic
//  Command chain and checks:
//   - CMD0 (arg 0): R1 must be 8'h01, else code 2
//   - CMD8 (arg 32'h1AA): R1 must be 8'h01 and ext[11:0]=12'h1AA, else code 3
//     (R1=8'h05, SDv1 card, is code 3)
//   - CMD55: R1 must be 8'h00 or 8'h01, else code 4; then ACMD41 (arg 32'h40000000)
//   - ACMD41: R1=8'h01 -> retry counter+1, back to CMD55
//     - counter reaching ACMD41_RETRY -> code 4; R1=8'h00 -> CMD58; any other R1 -> code 4
//   - CMD58: R1 must be 8'h00, else code 5
//     - ocr_o<=ext; card_hc_o<=ext[30]
//  DONE: ready_o=1, busy_o=0, divider=FAST_DIV, CS high -> IDLE (flags sticky).
//  ERROR: error_o=1, busy_o=0, divider=SLOW_DIV, CS high -> IDLE.
//  Frame: {2'b01, idx[5:0], arg[31:0], crc7[6:0], 1'b1}. Retry counter is $clog2(ACMD41_RETRY+1) bits and saturates.
// CONFIGURATION
//  SD_SEQ_CRC7_EN defined:
//   - CRC7 is computed serially over the first 40 frame bits by the sub-module
//   - SEND_CMD then waits 40 cycles before byte 0
//  SD_SEQ_CRC7_EN undefined:
//   - fixed trailer bytes: CMD0 8'h95, CMD8 8'h87, others 8'h01
//   - byte 0 goes out the cycle after entry to SEND_CMD
//  Frames sent on the wire are identical in both builds.
// STRUCTURE
//  sd_spi_pkg: state encoding, command indices (0,8,55,41,58), arguments, fixed CRC bytes,
//   error codes (0 none,1 R1 timeout,2 CMD0,3 CMD8,4 ACMD41,5 CMD58).
//  Sub-module sd_crc7 (start/bit/valid serial CRC7, poly x^7+x^3+1), instantiated only under SD_SEQ_CRC7_EN.
// TESTING
//  - Card model answers 01,01+000001AA,01,00,00+C0FF8000:
//    - ready_o=1, card_hc_o=1, ocr_o=32'hC0FF8000, divider=2'b00
//  - First CMD0 frame on wire = 40 00 00 00 00 95; 10 leading 0xFF bytes with CS high
//  - Model never drives rx[7]=0 after CMD0: after 8 polled bytes, error_o=1, error_code_o=1
//  - CMD8 echo 000001AB: error_code_o=3, no CMD55 frame issued
//  - ACMD41 returns 01 forever (ACMD41_RETRY=4): exactly 4 CMD55/ACMD41 pairs, then error_code_o=4
//  - seq_rst_i asserted mid CMD8 frame:
//    - spi_cs_n_o=1, busy_o=0 that cycle; a new start_i restarts from POWERUP
//    - run both with and without SD_SEQ_CRC7_EN

Source files
------------

// File: rtl/sd_spi_pkg.sv
// sd_spi_pkg
// Shared definitions for the SD-card SPI-mode init sequencer.
// Contents:
//   - FSM state encoding
//   - command selector, command indices and arguments
//   - fixed CRC trailer bytes and error codes
//   - helper functions that build the 40-bit frame head and pick the fixed
//     trailer byte for a command
package sd_spi_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_POWERUP,
    ST_SEND_CMD,
    ST_WAIT_R1,
    ST_READ_EXT,
    ST_GAP,
    ST_EVAL,
    ST_DONE,
    ST_ERROR
  } seq_state_t;

  typedef enum logic [2:0] {
    CMD_GO_IDLE,
    CMD_IF_COND,
    CMD_APP,
    CMD_SD_OP_COND,
    CMD_READ_OCR
  } cmd_sel_t;

  localparam logic [5:0] IDX_CMD0   = 6'd0;
  localparam logic [5:0] IDX_CMD8   = 6'd8;
  localparam logic [5:0] IDX_CMD55  = 6'd55;
  localparam logic [5:0] IDX_ACMD41 = 6'd41;
  localparam logic [5:0] IDX_CMD58  = 6'd58;

  localparam logic [31:0] ARG_NONE   = 32'h0000_0000;
  localparam logic [31:0] ARG_CMD8   = 32'h0000_01AA;
  localparam logic [31:0] ARG_ACMD41 = 32'h4000_0000;

  localparam logic [7:0] CRC_CMD0  = 8'h95;
  localparam logic [7:0] CRC_CMD8  = 8'h87;
  localparam logic [7:0] CRC_OTHER = 8'h01;

  localparam logic [2:0] ERR_NONE       = 3'd0;
  localparam logic [2:0] ERR_R1_TIMEOUT = 3'd1;
  localparam logic [2:0] ERR_CMD0       = 3'd2;
  localparam logic [2:0] ERR_CMD8       = 3'd3;
  localparam logic [2:0] ERR_ACMD41     = 3'd4;
  localparam logic [2:0] ERR_CMD58      = 3'd5;

  // Start bits, command index and argument: everything the CRC7 covers.
  function automatic logic [39:0] frame_head(input cmd_sel_t c);
    logic [39:0] head;
    case (c)
      CMD_GO_IDLE:    head = {2'b01, IDX_CMD0,   ARG_NONE};
      CMD_IF_COND:    head = {2'b01, IDX_CMD8,   ARG_CMD8};
      CMD_APP:        head = {2'b01, IDX_CMD55,  ARG_NONE};
      CMD_SD_OP_COND: head = {2'b01, IDX_ACMD41, ARG_ACMD41};
      CMD_READ_OCR:   head = {2'b01, IDX_CMD58,  ARG_NONE};
      default:        head = {2'b01, IDX_CMD0,   ARG_NONE};
    endcase
    return head;
  endfunction

  function automatic logic [7:0] fixed_trailer(input cmd_sel_t c);
    logic [7:0] t;
    case (c)
      CMD_GO_IDLE: t = CRC_CMD0;
      CMD_IF_COND: t = CRC_CMD8;
      default:     t = CRC_OTHER;
    endcase
    return t;
  endfunction

  // Commands whose response carries 4 bytes after R1 (R7 / R3).
  function automatic logic has_ext(input cmd_sel_t c);
    return (c == CMD_IF_COND) || (c == CMD_READ_OCR);
  endfunction

endpackage

// File: rtl/sd_crc7.sv
// sd_crc7
// Serial CRC7 (polynomial x^7 + x^3 + 1), one message bit per cycle, MSB first.
// Ports:
//   clk      clock
//   rst      asynchronous active-high reset
//   start    clears the remainder (takes priority over valid)
//   data_bit message bit
//   valid    data_bit is consumed this cycle
//   crc      current remainder
module sd_crc7 (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       data_bit,
  input  logic       valid,
  output logic [6:0] crc
);

  // LFSR form: feedback is the incoming bit XOR the remainder MSB, folded
  // back into taps 3 and 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      crc <= 7'd0;
    end else if (start) begin
      crc <= 7'd0;
    end else if (valid) begin
      crc <= {crc[5:0], 1'b0} ^ ({7{data_bit ^ crc[6]}} & 7'h09);
    end
  end

endmodule

// File: rtl/sd_init_sequencer.sv
// sd_init_sequencer
// Drives a byte-wide SPI master through SD-card SPI-mode initialisation.
// The sequence is 80 power-up clocks, CMD0, CMD8, a CMD55/ACMD41 poll loop,
// then CMD58. The block owns chip-select and the SCK divider select.
// Optional build macro SD_SEQ_CRC7_EN: when defined, the CMD0/CMD8 CRC is
// computed serially by sd_crc7. Each command then spends 40 cycles on the CRC
// before byte 0. When undefined, fixed trailer bytes are used.
// Ports:
//   seq_clk_i / seq_rst_i   clock, asynchronous active-high reset
//   start_i                 pulse: begin initialisation (ignored while busy)
//   spi_rx_i / spi_done_i   received byte, exchange-complete pulse
//   spi_tx_o / spi_start_o  byte to send, exchange-start pulse
//   spi_cs_n_o              card chip-select, active low
//   clock_divider_o         SPI master SCK divider select
//   busy_o / ready_o / error_o / error_code_o   status (ready/error sticky)
//   card_hc_o / ocr_o       CCS bit and OCR from CMD58
module sd_init_sequencer
  import sd_spi_pkg::*;
#(
  parameter int         POWERUP_BYTES = 10,
  parameter int         NCR_MAX       = 8,
  parameter int         ACMD41_RETRY  = 1000,
  parameter logic [1:0] SLOW_DIV      = 2'b11,
  parameter logic [1:0] FAST_DIV      = 2'b00
) (
  input  logic        seq_clk_i,
  input  logic        seq_rst_i,
  input  logic        start_i,
  input  logic [7:0]  spi_rx_i,
  input  logic        spi_done_i,
  output logic [7:0]  spi_tx_o,
  output logic        spi_start_o,
  output logic        spi_cs_n_o,
  output logic [1:0]  clock_divider_o,
  output logic        busy_o,
  output logic        ready_o,
  output logic        error_o,
  output logic [2:0]  error_code_o,
  output logic        card_hc_o,
  output logic [31:0] ocr_o
);

  localparam int CNT_W = 8;
  localparam int RC_W  = $clog2(ACMD41_RETRY + 1);

  seq_state_t       state, state_nxt;
  cmd_sel_t         cmd, cmd_nxt;
  logic [2:0]       code_nxt;
  logic [CNT_W-1:0] byte_cnt;
  logic [RC_W-1:0]  retry_cnt;
  logic             in_flight;
  logic [7:0]       r1;
  logic [31:0]      ext;
  logic             byte_phase;
  logic             byte_done;
  logic             enter_cmd;
  logic             crc_ready;
  logic [7:0]       trailer;
  logic [47:0]      frame;

  assign byte_done = spi_done_i & in_flight;
  assign frame     = {frame_head(cmd), trailer};
  assign enter_cmd = (state_nxt == ST_SEND_CMD) && (state != ST_SEND_CMD);

`ifdef SD_SEQ_CRC7_EN
  logic [5:0]  crc_cnt;
  logic [39:0] crc_sreg;
  logic [6:0]  crc7;
  logic        crc_feed;

  assign crc_feed  = (state == ST_SEND_CMD) && (crc_cnt != 6'd40);
  assign crc_ready = !crc_feed;
  // The card only checks CRC on CMD0/CMD8 in SPI mode. The other commands keep
  // the 01 trailer, so both builds put identical frames on the wire.
  assign trailer   = ((cmd == CMD_GO_IDLE) || (cmd == CMD_IF_COND)) ? {crc7, 1'b1} : CRC_OTHER;

  // Feed the 40 head bits MSB-first into the CRC, one per cycle, starting on
  // SEND_CMD entry. No SPI byte starts until all 40 are consumed.
  always_ff @(posedge seq_clk_i or posedge seq_rst_i) begin
    if (seq_rst_i) begin
      crc_cnt  <= 6'd0;
      crc_sreg <= 40'd0;
    end else if (enter_cmd) begin
      crc_cnt  <= 6'd0;
      crc_sreg <= frame_head(cmd_nxt);
    end else if (crc_feed) begin
      crc_cnt  <= crc_cnt + 6'd1;
      crc_sreg <= {crc_sreg[38:0], 1'b0};
    end
  end

  sd_crc7 u_crc7 (
    .clk      (seq_clk_i),
    .rst      (seq_rst_i),
    .start    (enter_cmd),
    .data_bit (crc_sreg[39]),
    .valid    (crc_feed),
    .crc      (crc7)
  );
`else
  assign crc_ready = 1'b1;
  assign trailer   = fixed_trailer(cmd);
`endif

  // States that exchange bytes with the SPI master. A new byte starts whenever
  // none is outstanding. CS is low only while a command is framed or answered.
  always_comb begin
    byte_phase  = (state == ST_POWERUP) || (state == ST_SEND_CMD) || (state == ST_WAIT_R1) ||
                  (state == ST_READ_EXT) || (state == ST_GAP);
    spi_start_o = byte_phase && !in_flight && crc_ready;
    spi_cs_n_o  = !((state == ST_SEND_CMD) || (state == ST_WAIT_R1) || (state == ST_READ_EXT));
    busy_o      = (state != ST_IDLE) && (state != ST_DONE) && (state != ST_ERROR);
    spi_tx_o    = 8'hFF;
    if (state == ST_SEND_CMD) begin
      case (byte_cnt[2:0])
        3'd0:    spi_tx_o = frame[47:40];
        3'd1:    spi_tx_o = frame[39:32];
        3'd2:    spi_tx_o = frame[31:24];
        3'd3:    spi_tx_o = frame[23:16];
        3'd4:    spi_tx_o = frame[15:8];
        default: spi_tx_o = frame[7:0];
      endcase
    end
  end

  always_ff @(posedge seq_clk_i or posedge seq_rst_i) begin
    if (seq_rst_i) state <= ST_IDLE;
    else           state <= state_nxt;
  end

  // Next state, plus the command to issue next and the failure cause.
  always_comb begin
    state_nxt = state;
    cmd_nxt   = cmd;
    code_nxt  = ERR_NONE;
    case (state)
      ST_IDLE: if (start_i) state_nxt = ST_POWERUP;
      ST_POWERUP:
        if (byte_done && byte_cnt == CNT_W'(POWERUP_BYTES - 1)) begin
          state_nxt = ST_SEND_CMD;
          cmd_nxt   = CMD_GO_IDLE;
        end
      ST_SEND_CMD:
        if (byte_done && byte_cnt == CNT_W'(5)) state_nxt = ST_WAIT_R1;
      ST_WAIT_R1:
        if (byte_done) begin
          if (!spi_rx_i[7]) begin
            state_nxt = has_ext(cmd) ? ST_READ_EXT : ST_GAP;
          end else if (byte_cnt == CNT_W'(NCR_MAX - 1)) begin
            state_nxt = ST_ERROR;
            code_nxt  = ERR_R1_TIMEOUT;
          end
        end
      ST_READ_EXT:
        if (byte_done && byte_cnt == CNT_W'(3)) state_nxt = ST_GAP;
      ST_GAP:
        if (byte_done) state_nxt = ST_EVAL;
      ST_EVAL: begin
        state_nxt = ST_ERROR;
        case (cmd)
          CMD_GO_IDLE:
            if (r1 == 8'h01) begin
              state_nxt = ST_SEND_CMD;
              cmd_nxt   = CMD_IF_COND;
            end else code_nxt = ERR_CMD0;
          CMD_IF_COND:
            if (r1 == 8'h01 && ext[11:0] == 12'h1AA) begin
              state_nxt = ST_SEND_CMD;
              cmd_nxt   = CMD_APP;
            end else code_nxt = ERR_CMD8;
          CMD_APP:
            if (r1 == 8'h00 || r1 == 8'h01) begin
              state_nxt = ST_SEND_CMD;
              cmd_nxt   = CMD_SD_OP_COND;
            end else code_nxt = ERR_ACMD41;
          CMD_SD_OP_COND:
            // R1=01 means the card is still initialising: try again unless
            // this was the last permitted iteration.
            if (r1 == 8'h00) begin
              state_nxt = ST_SEND_CMD;
              cmd_nxt   = CMD_READ_OCR;
            end else if (r1 == 8'h01 && retry_cnt < RC_W'(ACMD41_RETRY - 1)) begin
              state_nxt = ST_SEND_CMD;
              cmd_nxt   = CMD_APP;
            end else code_nxt = ERR_ACMD41;
          CMD_READ_OCR:
            if (r1 == 8'h00) state_nxt = ST_DONE;
            else code_nxt = ERR_CMD58;
          default: code_nxt = ERR_CMD0;
        endcase
      end
      ST_DONE:  state_nxt = ST_IDLE;
      ST_ERROR: state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Byte bookkeeping, response capture and the sticky status outputs.
  always_ff @(posedge seq_clk_i or posedge seq_rst_i) begin
    if (seq_rst_i) begin
      in_flight       <= 1'b0;
      byte_cnt        <= '0;
      retry_cnt       <= '0;
      cmd             <= CMD_GO_IDLE;
      r1              <= 8'h00;
      ext             <= 32'd0;
      ready_o         <= 1'b0;
      error_o         <= 1'b0;
      error_code_o    <= ERR_NONE;
      card_hc_o       <= 1'b0;
      ocr_o           <= 32'd0;
      clock_divider_o <= SLOW_DIV;
    end else begin
      if (spi_start_o)     in_flight <= 1'b1;
      else if (spi_done_i) in_flight <= 1'b0;

      if (state_nxt != state) byte_cnt <= '0;
      else if (byte_done)     byte_cnt <= byte_cnt + CNT_W'(1);

      if (enter_cmd) cmd <= cmd_nxt;

      if (byte_done && state == ST_WAIT_R1 && !spi_rx_i[7]) r1 <= spi_rx_i;
      if (byte_done && state == ST_READ_EXT) ext <= {ext[23:0], spi_rx_i};

      if (state == ST_EVAL && cmd == CMD_SD_OP_COND && r1 == 8'h01 &&
          retry_cnt < RC_W'(ACMD41_RETRY))
        retry_cnt <= retry_cnt + RC_W'(1);

      if (state == ST_EVAL && cmd == CMD_READ_OCR && r1 == 8'h00) begin
        ocr_o     <= ext;
        card_hc_o <= ext[30];
      end

      if (state_nxt == ST_ERROR && state != ST_ERROR) error_code_o <= code_nxt;

      case (state)
        ST_IDLE:
          if (start_i) begin
            ready_o         <= 1'b0;
            error_o         <= 1'b0;
            error_code_o    <= ERR_NONE;
            card_hc_o       <= 1'b0;
            ocr_o           <= 32'd0;
            retry_cnt       <= '0;
            clock_divider_o <= SLOW_DIV;
          end
        ST_DONE: begin
          ready_o         <= 1'b1;
          clock_divider_o <= FAST_DIV;
        end
        ST_ERROR: begin
          error_o         <= 1'b1;
          clock_divider_o <= SLOW_DIV;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sd_init_sequencer.sv
// tb_sd_init_sequencer
// Directed bench for sd_init_sequencer, built with ACMD41_RETRY=4.
// A behavioural card model sits on the byte handshake. It logs every 6-byte
// frame sent with CS low and answers from a per-test script.
// Card modes:
//   0 = healthy SDHC card
//   1 = silent after CMD0
//   2 = bad CMD8 echo
//   3 = ACMD41 busy forever
module tb_sd_init_sequencer;

  logic        seq_clk = 1'b0;
  logic        seq_rst = 1'b1;
  logic        start   = 1'b0;
  logic [7:0]  spi_rx  = 8'hFF;
  logic        spi_done = 1'b0;
  logic [7:0]  spi_tx_o;
  logic        spi_start_o;
  logic        spi_cs_n_o;
  logic [1:0]  clock_divider_o;
  logic        busy_o;
  logic        ready_o;
  logic        error_o;
  logic [2:0]  error_code_o;
  logic        card_hc_o;
  logic [31:0] ocr_o;

  int n_checks = 0;
  int n_pass   = 0;
  int card_mode = 0;

  localparam logic [47:0] FR_CMD0   = 48'h40_00000000_95;
  localparam logic [47:0] FR_CMD8   = 48'h48_000001AA_87;
  localparam logic [47:0] FR_CMD55  = 48'h77_00000000_01;
  localparam logic [47:0] FR_ACMD41 = 48'h69_40000000_01;
  localparam logic [47:0] FR_CMD58  = 48'h7A_00000000_01;

  always #5 seq_clk = ~seq_clk;

  sd_init_sequencer #(.ACMD41_RETRY(4)) dut (
    .seq_clk_i       (seq_clk),
    .seq_rst_i       (seq_rst),
    .start_i         (start),
    .spi_rx_i        (spi_rx),
    .spi_done_i      (spi_done),
    .spi_tx_o        (spi_tx_o),
    .spi_start_o     (spi_start_o),
    .spi_cs_n_o      (spi_cs_n_o),
    .clock_divider_o (clock_divider_o),
    .busy_o          (busy_o),
    .ready_o         (ready_o),
    .error_o         (error_o),
    .error_code_o    (error_code_o),
    .card_hc_o       (card_hc_o),
    .ocr_o           (ocr_o)
  );

  // Card model state. Logs are cleared whenever reset is held.
  logic [47:0] frames [0:31];
  int          frames_n;
  int          col_cnt;
  logic [47:0] col;
  bit          in_resp;
  bit          pending;
  logic [7:0]  next_rx;
  int          hi_pre;
  int          poll_bytes;
  logic [7:0]  resp_q [$];

  // Card model, evaluated on the falling edge. A start seen here is answered
  // with a one-cycle done on the next falling edge. CS-high bytes reset the
  // framing. After a full frame the scripted response is queued: one 0xFF of
  // Ncr, then R1 and any extension bytes.
  always @(negedge seq_clk) begin
    if (seq_rst) begin
      pending = 1'b0; spi_done = 1'b0; spi_rx = 8'hFF;
      in_resp = 1'b0; col_cnt = 0; col = '0; frames_n = 0; hi_pre = 0; poll_bytes = 0;
      resp_q.delete();
    end else begin
      spi_done = 1'b0;
      if (pending) begin
        spi_done = 1'b1;
        spi_rx   = next_rx;
        pending  = 1'b0;
      end else if (spi_start_o) begin
        pending = 1'b1;
        next_rx = 8'hFF;
        if (spi_cs_n_o) begin
          in_resp = 1'b0; col_cnt = 0; resp_q.delete();
          if (frames_n == 0) hi_pre++;
        end else if (!in_resp) begin
          col = {col[39:0], spi_tx_o};
          col_cnt++;
          if (col_cnt == 6) begin
            if (frames_n < 32) frames[frames_n] = col;
            frames_n++;
            col_cnt = 0; in_resp = 1'b1; poll_bytes = 0;
            case (col[45:40])
              6'd0:  if (card_mode != 1) begin resp_q.push_back(8'hFF); resp_q.push_back(8'h01); end
              6'd8:  begin
                resp_q.push_back(8'hFF); resp_q.push_back(8'h01); resp_q.push_back(8'h00);
                resp_q.push_back(8'h00); resp_q.push_back(8'h01);
                resp_q.push_back(card_mode == 2 ? 8'hAB : 8'hAA);
              end
              6'd55: begin resp_q.push_back(8'hFF); resp_q.push_back(8'h01); end
              6'd41: begin resp_q.push_back(8'hFF); resp_q.push_back(card_mode == 3 ? 8'h01 : 8'h00); end
              6'd58: begin
                resp_q.push_back(8'hFF); resp_q.push_back(8'h00); resp_q.push_back(8'hC0);
                resp_q.push_back(8'hFF); resp_q.push_back(8'h80); resp_q.push_back(8'h00);
              end
              default: ;
            endcase
          end
        end else begin
          poll_bytes++;
          if (resp_q.size() > 0) next_rx = resp_q.pop_front();
        end
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    n_checks++;
    if (observed !== expected)
      $display("[TB] FAIL %s: observed %0h required %0h", tag, observed, expected);
    else
      n_pass++;
  endtask

  // Reset the DUT and card model, choose the card script, pulse start.
  task automatic applyStimulus(input int mode);
    card_mode = mode;
    @(negedge seq_clk); seq_rst = 1'b1;
    repeat (3) @(negedge seq_clk);
    seq_rst = 1'b0;
    @(negedge seq_clk); start = 1'b1;
    @(negedge seq_clk); start = 1'b0;
  endtask

  task automatic waitFinished(input string tag);
    bit ok = 1'b0;
    for (int i = 0; i < 20000; i++) begin
      @(negedge seq_clk);
      if (ready_o || error_o) begin ok = 1'b1; break; end
    end
    checkOutput(tag, 64'(ok), 64'd1);
  endtask

  initial begin
    int n55;
    int n41;
    bit reached;

    // Reset values, sampled while reset is held.
    repeat (3) @(negedge seq_clk);
    checkOutput("rst_cs_n", 64'(spi_cs_n_o), 64'd1);
    checkOutput("rst_tx", 64'(spi_tx_o), 64'hFF);
    checkOutput("rst_div", 64'(clock_divider_o), 64'd3);
    checkOutput("rst_flags", 64'({spi_start_o, busy_o, ready_o, error_o, card_hc_o}), 64'd0);
    checkOutput("rst_code_ocr", 64'({error_code_o, ocr_o}), 64'd0);

    // Healthy SDHC card: full sequence succeeds.
    applyStimulus(0);
    waitFinished("ok_finish");
    repeat (2) @(negedge seq_clk);
    checkOutput("ok_ready", 64'({ready_o, error_o, busy_o}), 64'b100);
    checkOutput("ok_hc", 64'(card_hc_o), 64'd1);
    checkOutput("ok_ocr", 64'(ocr_o), 64'hC0FF8000);
    checkOutput("ok_div", 64'(clock_divider_o), 64'd0);
    checkOutput("ok_cs_idle", 64'(spi_cs_n_o), 64'd1);
    checkOutput("ok_powerup", 64'(hi_pre), 64'd10);
    checkOutput("ok_nframes", 64'(frames_n), 64'd5);
    checkOutput("ok_fr0", 64'(frames[0]), 64'(FR_CMD0));
    checkOutput("ok_fr1", 64'(frames[1]), 64'(FR_CMD8));
    checkOutput("ok_fr2", 64'(frames[2]), 64'(FR_CMD55));
    checkOutput("ok_fr3", 64'(frames[3]), 64'(FR_ACMD41));
    checkOutput("ok_fr4", 64'(frames[4]), 64'(FR_CMD58));

    // Silent card: R1 never arrives after CMD0.
    applyStimulus(1);
    waitFinished("nr_finish");
    repeat (2) @(negedge seq_clk);
    checkOutput("nr_flags", 64'({ready_o, error_o}), 64'b01);
    checkOutput("nr_code", 64'(error_code_o), 64'd1);
    checkOutput("nr_polls", 64'(poll_bytes), 64'd8);
    checkOutput("nr_nframes", 64'(frames_n), 64'd1);

    // Wrong CMD8 echo pattern: error 3, no CMD55.
    applyStimulus(2);
    waitFinished("c8_finish");
    repeat (2) @(negedge seq_clk);
    checkOutput("c8_code", 64'({error_o, error_code_o}), 64'({1'b1, 3'd3}));
    checkOutput("c8_nframes", 64'(frames_n), 64'd2);

    // ACMD41 stays busy: exactly 4 CMD55/ACMD41 pairs, then error 4.
    applyStimulus(3);
    waitFinished("a41_finish");
    repeat (2) @(negedge seq_clk);
    checkOutput("a41_code", 64'({error_o, error_code_o}), 64'({1'b1, 3'd4}));
    n55 = 0; n41 = 0;
    for (int i = 0; i < frames_n && i < 32; i++) begin
      if (frames[i] == FR_CMD55)  n55++;
      if (frames[i] == FR_ACMD41) n41++;
    end
    checkOutput("a41_pairs", 64'({n55[15:0], n41[15:0]}), 64'h0004_0004);
    checkOutput("a41_nframes", 64'(frames_n), 64'd10);
    checkOutput("a41_div", 64'(clock_divider_o), 64'd3);

    // Reset in the middle of the CMD8 frame, then restart.
    applyStimulus(0);
    reached = 1'b0;
    for (int i = 0; i < 5000; i++) begin
      @(negedge seq_clk);
      if (frames_n == 1 && col_cnt >= 2) begin reached = 1'b1; break; end
    end
    checkOutput("mid_reached", 64'(reached), 64'd1);
    checkOutput("mid_busy_slow", 64'({busy_o, clock_divider_o}), 64'({1'b1, 2'b11}));
    seq_rst = 1'b1;
    #1;
    checkOutput("mid_rst_cs", 64'({spi_cs_n_o, busy_o}), 64'b10);
    repeat (2) @(negedge seq_clk);
    seq_rst = 1'b0;
    @(negedge seq_clk); start = 1'b1;
    @(negedge seq_clk); start = 1'b0;
    waitFinished("re_finish");
    repeat (2) @(negedge seq_clk);
    checkOutput("re_ready", 64'(ready_o), 64'd1);
    checkOutput("re_powerup", 64'(hi_pre), 64'd10);
    checkOutput("re_fr0", 64'(frames[0]), 64'(FR_CMD0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
